// File: rtl/sampler_ctrl_if.sv
// ADC sample input and buffer RAM write port of the sampler controller.
// master = controller side, slave = ADC source / sample buffer side.
interface sampler_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic [DATA_WIDTH-1:0] adc_sampler_data;
    logic                  adc_sampler_valid;
    logic                  sampler_mem_we;
    logic [ADDR_WIDTH-1:0] sampler_mem_addr;
    logic [DATA_WIDTH-1:0] sampler_mem_wdata;

    modport master (
        input  adc_sampler_data,
        input  adc_sampler_valid,
        output sampler_mem_we,
        output sampler_mem_addr,
        output sampler_mem_wdata
    );

    modport slave (
        output adc_sampler_data,
        output adc_sampler_valid,
        input  sampler_mem_we,
        input  sampler_mem_addr,
        input  sampler_mem_wdata
    );
endinterface

// File: rtl/sampler_ctrl.sv
// Capture-run controller: on a rising start edge, stores NUM_SAMPLES decimated
// ADC samples into the sample buffer and reports busy/done/count.
module sampler_ctrl #(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned NUM_SAMPLES = 1024,
    parameter int unsigned DECIM       = 1
) (
    input  logic                  clk_sampler,
    input  logic                  rst_sampler_n_sync,
    input  logic                  startsync_sampler_start_r_sync,
    sampler_ctrl_if.master        bus,
    output logic                  sampler_busy,
    output logic                  sampler_done,
    output logic [ADDR_WIDTH:0]   sampler_count
);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] NUM_C      = CNT_W'(NUM_SAMPLES);
    localparam logic [DEC_W-1:0] DECIM_LAST = DEC_W'(DECIM - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                r_state;
    logic                  r_start_d;
    logic                  r_edge_en;
    logic                  r_we;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CNT_W-1:0]      r_count;
    logic [DEC_W-1:0]      r_decim;

    logic w_start_rise;
    logic w_room;
    logic w_take;
    logic w_store;

    // r_edge_en masks the first post-reset cycle so a start already high at release is not an edge
    assign w_start_rise = startsync_sampler_start_r_sync & ~r_start_d & r_edge_en;
    assign w_room       = (r_count < NUM_C);
    assign w_take       = (r_state == ST_RUN) && bus.adc_sampler_valid && w_room;
    assign w_store      = w_take && (r_decim == '0);

    always_ff @(posedge clk_sampler or negedge rst_sampler_n_sync) begin
        if (!rst_sampler_n_sync) begin
            r_state   <= ST_IDLE;
            r_start_d <= 1'b0;
            r_edge_en <= 1'b0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_count   <= '0;
            r_decim   <= '0;
        end else begin
            r_start_d <= startsync_sampler_start_r_sync;
            r_edge_en <= 1'b1;
            r_we      <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_rise) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_count <= '0;
                        r_addr  <= '0;
                        r_decim <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_take) begin
                        r_decim <= (r_decim == DECIM_LAST) ? '0 : r_decim + DEC_W'(1);
                    end
                    if (w_store) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_count[ADDR_WIDTH-1:0];
                        r_wdata <= bus.adc_sampler_data;
                        r_count <= r_count + CNT_W'(1);
                    end
                    // Final write is already out; close the run one cycle later
                    if (!w_room) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sampler_mem_we    = r_we;
    assign bus.sampler_mem_addr  = r_addr;
    assign bus.sampler_mem_wdata = r_wdata;
    assign sampler_busy          = r_busy;
    assign sampler_done          = r_done;
    assign sampler_count         = r_count;
endmodule

// File: doc/sampler_ctrl.md
Name: sampler_ctrl

Overview:
- Downstream consumer of the synchronized start level in the clk_sampler domain.
- Detects the rising edge of the start level and arms a capture run.
- Writes a fixed number of decimated ADC samples into the sample buffer RAM through a single write port.
- Reports busy/done status back to sampler top level.

Parameters:
DATA_WIDTH, 12, width of ADC sample and buffer write data
ADDR_WIDTH, 10, width of buffer address; NUM_SAMPLES <= 2**ADDR_WIDTH
NUM_SAMPLES, 1024, samples written per run (>= 1)
DECIM, 1, keep one of every DECIM valid ADC samples (>= 1)

Ports:
clk_sampler  input  1  sampler clock
rst_sampler_n_sync  input  1  asynchronous active-low reset, deassertion synchronous to clk_sampler
startsync_sampler_start_r_sync  input  1  synchronized start level; run begins on its rising edge
adc_sampler_data  input  DATA_WIDTH  ADC sample
adc_sampler_valid  input  1  adc_sampler_data valid this cycle
sampler_mem_we  output  1  buffer write enable, one-cycle pulse per stored sample
sampler_mem_addr  output  ADDR_WIDTH  buffer write address
sampler_mem_wdata  output  DATA_WIDTH  buffer write data
sampler_busy  output  1  high while a run is in progress
sampler_done  output  1  high from run completion until the next accepted start edge
sampler_count  output  ADDR_WIDTH+1  samples written in the current/last run

Behaviour:
- Reset: clock clk_sampler; reset rst_sampler_n_sync, asynchronous, active-low. All outputs 0, FSM = IDLE, start-edge register 0, decimation counter 0.
- Edge detect: register start_d <= start_r_sync each cycle. start_rise = start_r_sync & ~start_d.
  - A start held high never retriggers.
  - A start already high when reset deasserts does not trigger (start_d resets to 0 but is loaded on the first clock). The edge is evaluated only from the second post-reset cycle onward.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start_rise: clear sampler_count, address and decimation counter; busy=1 next cycle.
  - RUN: sample acceptance and writes as below; -> DONE the cycle after the write that makes count == NUM_SAMPLES.
  - DONE: busy=0, done=1. -> RUN on start_rise: done=0, busy=1 and counters cleared, all in the same transition.
  - RUN ignores start_rise; a restart mid-run is dropped, not queued.
- Sample acceptance (RUN only): the first usable valid is the cycle after the FSM enters RUN. A valid coincident with start_rise is not captured.
  - On each adc_sampler_valid, decim_cnt increments modulo DECIM.
  - The sample is stored when decim_cnt == 0 before the increment, so with DECIM=1 every valid is stored.
- Write timing: registered outputs, one-cycle latency.
  - A valid accepted in cycle N produces we=1 in cycle N+1, with wdata = data from cycle N and addr = the current sampler_count value.
  - sampler_count increments in that same cycle N+1.
  - we is 0 in all other cycles.
- Address sequence: 0, 1, ..., NUM_SAMPLES-1, with no wrap within a run. sampler_mem_addr holds its last value when idle.
- Completion: valids arriving after the final store (in the DONE transition cycle and later) are ignored. Exactly NUM_SAMPLES writes occur per run.
- sampler_count is the written total (width ADDR_WIDTH+1 so it can hold 2**ADDR_WIDTH). It holds its value in DONE and clears on the next start.
- Reset mid-run: outputs are forced to 0 immediately (asynchronously). No write is issued after reset assertion. The FSM returns to IDLE, and a fresh start edge is required.

Test Plan:
- Basic run (NUM_SAMPLES=8, DECIM=1, valid every cycle): start 0->1 -> busy rises 1 cycle later; 8 we pulses at addr 0..7 with wdata matching the inputs delayed 1 cycle; done=1, busy=0, count=8.
- Decimation (DECIM=3, NUM_SAMPLES=4, data = 0,1,2,...): stored wdata = 0,3,6,9 at addr 0..3; done after the 10th valid is processed.
- Sparse valid (valid every 5th cycle, NUM_SAMPLES=4): exactly 4 writes, each 1 cycle after its valid; busy stays high between; no writes after done.
- Start abuse: start held high through the full run -> exactly one run. A second pulse mid-run is ignored (write count stays NUM_SAMPLES). A new 0->1 edge in DONE restarts: done falls, count clears to 0, addr sequence restarts at 0.
- Reset mid-run (after 3 of 8 writes): we, busy, done and count go to 0 immediately. After release with start still high -> stays IDLE. A fresh edge gives a full 8-sample run.
- Full-range (ADDR_WIDTH=4, NUM_SAMPLES=16): last write at addr 15; count=16 without overflow; valid coincident with start_rise is not stored.
